// File: rtl/lsh_pkg.sv
// Shared types for the k-mer streaming hash path: base symbol, default window type,
// controller FSM states and the FNV-1a constants used by the window hasher.
package lsh_pkg;

    localparam int KMER_SIZE_DEFAULT = 16;

    localparam logic [31:0] FNV_OFFSET = 32'h811c9dc5;
    localparam logic [31:0] FNV_PRIME  = 32'h01000193;

    // A=00, C=01, G=10, T=11 so that bitwise inversion is the complement base
    typedef logic [1:0] base_t;

    typedef base_t [KMER_SIZE_DEFAULT-1:0] kmer_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/kmer_stream_ctrl_hasher.sv
// Combinational window hasher: FNV-1a over the KMER_SIZE symbols (most significant symbol first),
// bucket index is the 32-bit hash XOR-folded down to LOG2_NUM_OF_BUCKETS bits.
module kmer_stream_ctrl_hasher
    import lsh_pkg::*;
#(
    parameter int KMER_SIZE           = KMER_SIZE_DEFAULT,
    parameter int LOG2_NUM_OF_BUCKETS = 8
) (
    input  logic [2*KMER_SIZE-1:0]         key,
    output logic [31:0]                    h1,
    output logic [LOG2_NUM_OF_BUCKETS-1:0] h2
);

    logic [31:0] acc;
    base_t       sym;

    always_comb begin
        acc = FNV_OFFSET;
        sym = '0;
        for (int i = KMER_SIZE - 1; i >= 0; i--) begin
            sym = 2'(key >> (2 * i));
            acc = (acc ^ {30'd0, sym}) * FNV_PRIME;
        end
        h1 = acc;
        h2 = '0;
        for (int c = 0; c < 32; c += LOG2_NUM_OF_BUCKETS) begin
            h2 = h2 ^ LOG2_NUM_OF_BUCKETS'(acc >> c);
        end
    end

endmodule

// File: rtl/kmer_stream_ctrl.sv
// Streaming k-mer controller: shifts accepted bases into a KMER_SIZE window and emits one hash per window.
// Build option KMER_CTRL_CANON_EN adds a reverse-complement window and hashes the canonical (smaller) k-mer.
module kmer_stream_ctrl
    import lsh_pkg::*;
#(
    parameter int KMER_SIZE           = KMER_SIZE_DEFAULT,
    parameter int LOG2_NUM_OF_BUCKETS = 8,
    parameter int NUM_OF_BUCKETS      = 2 ** LOG2_NUM_OF_BUCKETS,
    parameter int SEQ_LEN_W           = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [SEQ_LEN_W-1:0]           seq_len,
    input  logic                           abort,
    input  logic                           base_valid,
    output logic                           base_ready,
    input  logic [1:0]                     base,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_h1,
    output logic [LOG2_NUM_OF_BUCKETS-1:0] out_h2,
    output logic [SEQ_LEN_W-1:0]           out_idx,
    output logic                           busy,
    output logic                           done,
    output logic                           err_short
);

    localparam logic [SEQ_LEN_W-1:0] K_LEN   = SEQ_LEN_W'(KMER_SIZE);
    localparam logic [SEQ_LEN_W-1:0] K_LAST  = SEQ_LEN_W'(KMER_SIZE - 1);
    localparam logic [SEQ_LEN_W-1:0] SEQ_ONE = SEQ_LEN_W'(1);
    localparam logic [LOG2_NUM_OF_BUCKETS-1:0] BUCKET_MASK =
        LOG2_NUM_OF_BUCKETS'(NUM_OF_BUCKETS - 1);

    state_t                          state, state_nxt;
    base_t [KMER_SIZE-1:0]           kmer, kmer_nxt;
    logic  [2*KMER_SIZE-1:0]         kmer_flat, fwd_key, hash_key;
    logic  [SEQ_LEN_W-1:0]           len_q, cnt;
    logic  [31:0]                    hash_h1;
    logic  [LOG2_NUM_OF_BUCKETS-1:0] hash_h2;
    logic start_ok, abort_hit, accept, last_sym, win_load, out_hs, done_nxt, err_nxt;

    assign start_ok  = (state == ST_IDLE) && start && (seq_len >= K_LEN);
    assign abort_hit = abort && (state != ST_IDLE);
    assign out_hs    = out_valid && out_ready;
    assign last_sym  = (cnt == len_q - SEQ_ONE);
    assign busy      = (state != ST_IDLE);

    // Hash key is the window after the incoming symbol, oldest symbol in the top bits
    always_comb begin
        kmer_nxt  = {base, kmer[KMER_SIZE-1:1]};
        kmer_flat = kmer_nxt;
        fwd_key   = '0;
        for (int i = 0; i < KMER_SIZE; i++) begin
            fwd_key = {fwd_key[2*KMER_SIZE-3:0], 2'(kmer_flat >> (2 * i))};
        end
    end

`ifdef KMER_CTRL_CANON_EN
    base_t [KMER_SIZE-1:0]   rc, rc_nxt;
    logic  [2*KMER_SIZE-1:0] rc_flat, rc_key;

    // Reverse complement grows from index 0, so rc[0] is the complement of the newest base
    always_comb begin
        rc_nxt  = {rc[KMER_SIZE-2:0], ~base};
        rc_flat = rc_nxt;
        rc_key  = '0;
        for (int i = 0; i < KMER_SIZE; i++) begin
            rc_key = {rc_key[2*KMER_SIZE-3:0], 2'(rc_flat >> (2 * i))};
        end
        hash_key = (rc_key < fwd_key) ? rc_key : fwd_key;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc <= '0;
        end else if (start_ok) begin
            rc <= '0;
        end else if (accept) begin
            rc <= rc_nxt;
        end
    end
`else
    assign hash_key = fwd_key;
`endif

    kmer_stream_ctrl_hasher #(
        .KMER_SIZE           (KMER_SIZE),
        .LOG2_NUM_OF_BUCKETS (LOG2_NUM_OF_BUCKETS)
    ) u_hasher (
        .key (hash_key),
        .h1  (hash_h1),
        .h2  (hash_h2)
    );

    always_comb begin
        state_nxt  = state;
        base_ready = 1'b0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (seq_len >= K_LEN) begin
                        state_nxt = ST_FILL;
                    end else begin
                        done_nxt = 1'b1;
                        err_nxt  = 1'b1;
                    end
                end
            end
            ST_FILL:  base_ready = 1'b1;
            ST_RUN:   base_ready = !out_valid || out_ready;
            ST_DRAIN: begin
                if (out_hs) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase

        accept   = base_valid && base_ready && !abort_hit;
        win_load = accept && (cnt >= K_LAST);
        if (accept) begin
            if (last_sym) begin
                state_nxt = ST_DRAIN;
            end else if (state == ST_FILL && cnt == K_LAST) begin
                state_nxt = ST_RUN;
            end
        end

        // Abort wins over any handshake in the same cycle and never reports done
        if (abort_hit) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            done      <= 1'b0;
            err_short <= 1'b0;
        end else begin
            state     <= state_nxt;
            done      <= done_nxt;
            err_short <= err_nxt;
        end
    end

    // out_idx is the window start: accepted count after this symbol minus KMER_SIZE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kmer      <= '0;
            cnt       <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_h1    <= '0;
            out_h2    <= '0;
            out_idx   <= '0;
        end else begin
            if (start_ok) begin
                len_q <= seq_len;
                cnt   <= '0;
                kmer  <= '0;
            end else if (accept) begin
                kmer <= kmer_nxt;
                cnt  <= cnt + SEQ_ONE;
            end

            if (abort_hit) begin
                out_valid <= 1'b0;
            end else if (win_load) begin
                out_valid <= 1'b1;
                out_h1    <= hash_h1;
                out_h2    <= hash_h2 & BUCKET_MASK;
                out_idx   <= cnt - K_LAST;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kmer_stream_ctrl.sv
// Self-checking bench for kmer_stream_ctrl: table of sequences plus a result scoreboard fed by a window model.
// Honours KMER_CTRL_CANON_EN to model and check the canonical-hash build.
module tb_kmer_stream_ctrl;

    localparam int K     = 16;
    localparam int LOG2B = 8;
    localparam int W     = 16;

    typedef struct packed {
        logic [31:0]      h1;
        logic [LOG2B-1:0] h2;
        logic [W-1:0]     idx;
    } res_t;

    typedef struct {
        int         seq_len;
        int         prefix_len;
        logic [1:0] prefix_sym;
        logic [1:0] body_sym;
        bit         rand_body;
        int         stall_after;
        int         abort_after;
        int         reset_after;
        int         restart_at;
        int         exp_results;
        bit         exp_err;
        bit         chk_ref;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [W-1:0]     seq_len = '0;
    logic             abort = 1'b0;
    logic             base_valid = 1'b0;
    logic             base_ready;
    logic [1:0]       base = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_h1;
    logic [LOG2B-1:0] out_h2;
    logic [W-1:0]     out_idx;
    logic             busy;
    logic             done;
    logic             err_short;

    always #5 clk = ~clk;

    kmer_stream_ctrl #(
        .KMER_SIZE           (K),
        .LOG2_NUM_OF_BUCKETS (LOG2B),
        .NUM_OF_BUCKETS      (1 << LOG2B),
        .SEQ_LEN_W           (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seq_len    (seq_len),
        .abort      (abort),
        .base_valid (base_valid),
        .base_ready (base_ready),
        .base       (base),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_h1     (out_h1),
        .out_h2     (out_h2),
        .out_idx    (out_idx),
        .busy       (busy),
        .done       (done),
        .err_short  (err_short)
    );

    // Standalone hasher on the window a run of 2'b10 bases should produce
    logic [2*K-1:0]   ref_key;
    logic [31:0]      ref_h1;
    logic [LOG2B-1:0] ref_h2;
`ifdef KMER_CTRL_CANON_EN
    assign ref_key = {K{2'b01}};
`else
    assign ref_key = {K{2'b10}};
`endif
    kmer_stream_ctrl_hasher #(
        .KMER_SIZE           (K),
        .LOG2_NUM_OF_BUCKETS (LOG2B)
    ) u_ref (
        .key (ref_key),
        .h1  (ref_h1),
        .h2  (ref_h2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt, err_cnt, results, done_cyc, hs_cyc, model_idx;
    bit br_seen, stall_chk, in_acc, out_hs;
    logic [1:0]       win[$];
    res_t             sb[$];
    logic [31:0]      last_h1;
    logic [LOG2B-1:0] last_h2;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [31:0] model_h1(input logic [2*K-1:0] key);
        logic [31:0] h;
        h = 32'h811c9dc5;
        for (int i = K - 1; i >= 0; i--) begin
            h = (h ^ {30'd0, key[2*i +: 2]}) * 32'h01000193;
        end
        return h;
    endfunction

    function automatic logic [LOG2B-1:0] model_h2(input logic [31:0] h);
        return h[7:0] ^ h[15:8] ^ h[23:16] ^ h[31:24];
    endfunction

    function automatic logic [2*K-1:0] model_key();
        logic [2*K-1:0] fwd;
`ifdef KMER_CTRL_CANON_EN
        logic [2*K-1:0] rc;
        rc = '0;
        for (int i = 0; i < K; i++) rc = {rc[2*K-3:0], ~win[K-1-i]};
`endif
        fwd = '0;
        for (int i = 0; i < K; i++) fwd = {fwd[2*K-3:0], win[i]};
`ifdef KMER_CTRL_CANON_EN
        return (rc < fwd) ? rc : fwd;
`else
        return fwd;
`endif
    endfunction

    // One clock: observe at the falling edge, update model/scoreboard, return 1 after the rising edge
    task automatic cycle();
        res_t exp_r;
        logic [2*K-1:0] key;
        @(negedge clk);
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err_short) err_cnt++;
        if (base_ready) br_seen = 1'b1;
        if (stall_chk) begin
            checkOutput("stall_base_ready", base_ready, 0);
            checkOutput("stall_out_valid", out_valid, 1);
            if (sb.size() > 0) begin
                checkOutput("stall_h1", out_h1, sb[0].h1);
                checkOutput("stall_idx", out_idx, sb[0].idx);
            end
        end
        in_acc = base_valid && base_ready && !abort;
        out_hs = out_valid && out_ready && !abort;
        if (out_hs) begin
            if (sb.size() == 0) begin
                checkOutput("result_expected", 0, 1);
            end else begin
                exp_r = sb.pop_front();
                checkOutput("out_h1", out_h1, exp_r.h1);
                checkOutput("out_h2", out_h2, exp_r.h2);
                checkOutput("out_idx", out_idx, exp_r.idx);
                last_h1 = out_h1;
                last_h2 = out_h2;
                results++;
                hs_cyc = cyc;
            end
        end
        if (in_acc) begin
            win.push_back(base);
            if (win.size() > K) void'(win.pop_front());
            if (win.size() == K) begin
                key       = model_key();
                exp_r.h1  = model_h1(key);
                exp_r.h2  = model_h2(exp_r.h1);
                exp_r.idx = W'(model_idx);
                model_idx++;
                sb.push_back(exp_r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [1:0] syms[$];
        int si, stall_left, budget;
        bit stalled, ended, restarted, aborting;
        int start_cyc;
        si = 0; stall_left = 0; budget = 0;
        stalled = 0; ended = 0; restarted = 0; aborting = 0;
        for (int i = 0; i < v.seq_len; i++) begin
            if (i < v.prefix_len)  syms.push_back(v.prefix_sym);
            else if (v.rand_body)  syms.push_back(2'($urandom_range(0, 3)));
            else                   syms.push_back(v.body_sym);
        end
        win.delete(); sb.delete();
        model_idx = 0; results = 0; done_cnt = 0; err_cnt = 0;
        done_cyc = -1; hs_cyc = -100; br_seen = 0; stall_chk = 0;

        start = 1'b1; seq_len = W'(v.seq_len); base_valid = 1'b0; out_ready = 1'b1;
        cycle();
        start_cyc = cyc;
        start = 1'b0;

        if (v.exp_err) begin
            base_valid = 1'b1; base = 2'b01;
            repeat (4) cycle();
            base_valid = 1'b0;
            checkOutput("short_done_cnt", done_cnt, 1);
            checkOutput("short_err_cnt", err_cnt, 1);
            checkOutput("short_done_cycle", done_cyc, start_cyc + 1);
            checkOutput("short_base_ready", br_seen, 0);
            checkOutput("short_busy", busy, 0);
            return;
        end

        while (done_cnt == 0 && !ended && budget < 2000) begin
            budget++;
            base_valid = (si < syms.size());
            base       = base_valid ? syms[si] : 2'b00;
            out_ready  = 1'b1;
            stall_chk  = 1'b0;
            aborting   = 1'b0;
            if (v.stall_after >= 0 && results == v.stall_after && !stalled) begin
                stalled = 1; stall_left = 5;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0; stall_chk = 1'b1; stall_left--;
            end
            if (v.restart_at >= 0 && results == v.restart_at && !restarted) begin
                restarted = 1; start = 1'b1; seq_len = W'(5);
            end
            if (v.abort_after >= 0 && results == v.abort_after) begin
                abort = 1'b1; aborting = 1'b1;
            end
            if (v.reset_after >= 0 && results == v.reset_after) begin
                #2 rst_n = 1'b0;
                #1;
                checkOutput("rst_mid_out_valid", out_valid, 0);
                checkOutput("rst_mid_busy", busy, 0);
                checkOutput("rst_mid_base_ready", base_ready, 0);
                checkOutput("rst_mid_out_idx", out_idx, 0);
                checkOutput("rst_mid_out_h1", out_h1, 0);
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                ended = 1;
            end else begin
                cycle();
                if (in_acc) si++;
                if (aborting) ended = 1;
            end
            abort = 1'b0; start = 1'b0; seq_len = W'(v.seq_len);
        end
        stall_chk = 1'b0;
        base_valid = 1'b0;

        if (ended) begin
            repeat (3) cycle();
            checkOutput("cancel_no_done", done_cnt, 0);
            checkOutput("cancel_out_valid", out_valid, 0);
            checkOutput("cancel_busy", busy, 0);
        end else begin
            checkOutput("seq_done_cnt", done_cnt, 1);
            checkOutput("seq_results", results, v.exp_results);
            checkOutput("seq_sb_empty", sb.size(), 0);
            checkOutput("seq_done_cycle", done_cyc, hs_cyc + 1);
            checkOutput("seq_err", err_cnt, 0);
            checkOutput("seq_busy", busy, 0);
            if (v.chk_ref) begin
                checkOutput("ref_h1", last_h1, ref_h1);
                checkOutput("ref_h2", last_h2, ref_h2);
                checkOutput("ref_model_h1", ref_h1, model_h1(ref_key));
            end
        end
    endtask

    initial begin
        vec_t vecs[9];
`ifdef KMER_CTRL_CANON_EN
        vec_t       v_zero;
        logic [31:0]      zero_h1;
        logic [LOG2B-1:0] zero_h2;
`endif
        //            len pre psym   bsym  rnd stl abt rst rsa exp err ref
        vecs[0] = '{16,  0, 2'b00, 2'b10, 0,  -1, -1, -1, -1,  1, 0, 1};
        vecs[1] = '{20,  4, 2'b00, 2'b10, 0,  -1, -1, -1, -1,  5, 0, 1};
        vecs[2] = '{10,  0, 2'b00, 2'b00, 0,  -1, -1, -1, -1,  0, 1, 0};
        vecs[3] = '{30,  0, 2'b00, 2'b00, 1,   3, -1, -1, -1, 15, 0, 0};
        vecs[4] = '{30,  0, 2'b00, 2'b00, 1,  -1,  8, -1, -1, -1, 0, 0};
        vecs[5] = '{16,  0, 2'b00, 2'b01, 0,  -1, -1, -1, -1,  1, 0, 0};
        vecs[6] = '{25,  0, 2'b00, 2'b00, 1,  -1, -1,  3, -1, -1, 0, 0};
        vecs[7] = '{17,  0, 2'b00, 2'b00, 1,  -1, -1, -1,  1,  2, 0, 0};
        vecs[8] = '{16,  0, 2'b00, 2'b11, 0,  -1, -1, -1, -1,  1, 0, 0};

        #1 rst_n = 1'b0;
        #3;
        checkOutput("rst_base_ready", base_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err_short", err_short, 0);
        checkOutput("rst_out_h1", out_h1, 0);
        checkOutput("rst_out_h2", out_h2, 0);
        checkOutput("rst_out_idx", out_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 9; v++) applyStimulus(vecs[v]);

`ifdef KMER_CTRL_CANON_EN
        v_zero = vecs[8];
        v_zero.body_sym = 2'b00;
        applyStimulus(v_zero);
        zero_h1 = last_h1;
        zero_h2 = last_h2;
        applyStimulus(vecs[8]);
        checkOutput("canon_h1", last_h1, zero_h1);
        checkOutput("canon_h2", last_h2, zero_h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
